decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decodes RV32I instruction words and hands the ALU-control bundle to the execute stage: aluop, funct3, funct7, itype, operand selects and immediate.
- Sits between fetch and execute.
- Valid/ready on both sides; registered output plus an optional skid entry, so back-to-back traffic runs at full rate.

Parameters:
- SkidEn, 1, 1 = two-entry buffer (output register plus skid register); 0 = output register only.
- Xlen comes from core_pkg (32).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all buffered entries and the current input
- in_valid_i  in  1  fetch presents an instruction
- in_ready_o  out  1  decode can accept an instruction
- instr_i  in  32  instruction word
- pc_i  in  Xlen  instruction address
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute accepts the bundle
- pc_o  out  Xlen  registered pc_i
- rs1_o / rs2_o / rd_o  out  5 each  register indices, taken from instr[19:15] / [24:20] / [11:7]
- rd_we_o  out  1  destination write enable
- imm_o  out  Xlen  sign-extended immediate for the format
- funct3_o  out  3  instr[14:12]
- funct7_o  out  7  instr[31:25]
- itype_o  out  1  OP-IMM instruction
- aluop_o  out  aluop_e  Add, Branch or Funct (Sleft is never emitted)
- asel_o  out  2  ALU A select: 0 = rs1, 1 = pc, 2 = zero
- bsel_o  out  1  ALU B select: 0 = rs2, 1 = imm
- mem_read_o / mem_write_o / branch_o / jump_o / illegal_o  out  1 each  class flags

Behaviour:
Decode (combinational, by opcode):
- OP 0110011: Funct, itype 0, asel 0, bsel 0, rd_we 1.
- OP-IMM 0010011: Funct, itype 1, bsel 1, I-imm, rd_we 1.
- LUI: Add, asel 2, bsel 1, U-imm, rd_we 1.
- AUIPC: Add, asel 1, bsel 1, U-imm, rd_we 1.
- LOAD: Add, rs1+I-imm, mem_read 1, rd_we 1.
- STORE: Add, rs1+S-imm, mem_write 1, rd_we 0.
- BRANCH: Branch, asel 0, bsel 0, B-imm in imm_o, branch 1, rd_we 0.
- JAL: Add, pc+J-imm, jump 1, rd_we 1.
- JALR: Add, rs1+I-imm, jump 1, rd_we 1.
- Illegal: any other opcode, BRANCH with funct3 2 or 3, LOAD funct3 3/6/7, STORE funct3 >= 3. Then illegal_o = 1, rd_we/mem/branch/jump = 0, aluop Add.
- Register fields are passed through unconditionally.
- Immediates are sign-extended from instr[31]; B/J immediates have bit 0 = 0; U-imm is instr[31:12] followed by 12 zeros.

Handshake:
- An input transfer happens when in_valid_i && in_ready_o; an output transfer when out_valid_o && out_ready_i.
- Latency: an accepted instruction appears on the outputs the next cycle if the output register is empty or drains that cycle.
- SkidEn = 1:
  - in_ready_o = !skid_valid, registered so there is no combinational path from out_ready_i.
  - If the output register is stalled and a transfer arrives, it goes into skid and in_ready_o drops the next cycle.
  - When the output drains, skid moves to the output register.
- SkidEn = 0: in_ready_o = !out_valid_o || out_ready_i.
- Ordering is strict FIFO; no drop, no duplication.
- Output fields stay stable while out_valid_o && !out_ready_i.
- Simultaneous input and output transfer with the buffer holding one entry: occupancy stays at 1 and the new entry replaces the output.

Flush and reset:
- flush_i: next cycle out_valid_o = 0, skid empty, in_ready_o = 1. An input handshaking in the flush cycle is discarded. Flush overrides all concurrent events.
- rst_i: same effect as flush. Reset values: out_valid_o = 0, in_ready_o = 1 (after the reset edge), all data outputs 0, aluop_o = Add.
- Reset mid-stream: every buffered entry is lost and no partial bundle is emitted.

Test Plan:
- add x3,x1,x2: 0x002081B3 -> 1 cycle later aluop Funct, funct3 0, funct7 0x00, itype 0, rs1 1, rs2 2, rd 3, rd_we 1, asel 0, bsel 0.
- srai x5,x6,3: 0x40335293 -> aluop Funct, itype 1, funct3 5, funct7 0x20, imm_o 0x00000403, bsel 1, rd 5.
- beq x1,x2,-4: 0xFE208EE3 -> aluop Branch, branch_o 1, imm_o 0xFFFFFFFC, rd_we 0. Instruction 0x00000000 -> illegal_o 1, rd_we 0, mem flags 0.
- Backpressure (SkidEn = 1): hold out_ready_i = 0 and offer A, B, C back-to-back -> A in the output register, B in skid, in_ready_o = 0, C held. Release out_ready_i -> A, B, C appear in order, one per cycle.
- Both entries full, assert flush_i together with an input handshake -> next cycle out_valid_o = 0, in_ready_o = 1, and nothing from that cycle ever appears.
- Assert rst_i for 1 cycle mid-stream -> out_valid_o = 0 and in_ready_o = 1 afterwards. Next instruction 0x00500093 (addi x1,x0,5) -> imm_o 5, itype 1, after one cycle of latency.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: turns an instruction word into the ALU-control bundle for execute.
// One-cycle latency through the output register; the skid entry keeps full rate under stalls.

package core_pkg;
  localparam int Xlen = 32;

  typedef enum logic [1:0] {
    AluAdd    = 2'd0,
    AluSleft  = 2'd1,
    AluBranch = 2'd2,
    AluFunct  = 2'd3
  } aluop_e;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [Xlen-1:0] imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            itype;
    aluop_e          aluop;
    logic [1:0]      asel;
    logic            bsel;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } dec_t;
endpackage

module decode_stage
  import core_pkg::*;
#(
  parameter bit SkidEn = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [Xlen-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [Xlen-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic [Xlen-1:0] imm_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic            itype_o,
  output aluop_e          aluop_o,
  output logic [1:0]      asel_o,
  output logic            bsel_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [Xlen-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t            dec;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Illegal encodings leave every control field at its zero/Add default.
  always_comb begin
    dec        = '0;
    dec.pc     = pc_i;
    dec.rs1    = instr_i[19:15];
    dec.rs2    = instr_i[24:20];
    dec.rd     = instr_i[11:7];
    dec.funct3 = f3;
    dec.funct7 = instr_i[31:25];
    dec.aluop  = AluAdd;
    case (opc)
      OpcOp: begin
        dec.aluop = AluFunct;
        dec.rd_we = 1'b1;
      end
      OpcOpImm: begin
        dec.aluop = AluFunct;
        dec.itype = 1'b1;
        dec.bsel  = 1'b1;
        dec.imm   = imm_i;
        dec.rd_we = 1'b1;
      end
      OpcLui: begin
        dec.asel  = 2'd2;
        dec.bsel  = 1'b1;
        dec.imm   = imm_u;
        dec.rd_we = 1'b1;
      end
      OpcAuipc: begin
        dec.asel  = 2'd1;
        dec.bsel  = 1'b1;
        dec.imm   = imm_u;
        dec.rd_we = 1'b1;
      end
      OpcLoad: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
          dec.illegal = 1'b1;
        end else begin
          dec.bsel     = 1'b1;
          dec.imm      = imm_i;
          dec.mem_read = 1'b1;
          dec.rd_we    = 1'b1;
        end
      end
      OpcStore: begin
        if (f3 >= 3'd3) begin
          dec.illegal = 1'b1;
        end else begin
          dec.bsel      = 1'b1;
          dec.imm       = imm_s;
          dec.mem_write = 1'b1;
        end
      end
      OpcBranch: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          dec.illegal = 1'b1;
        end else begin
          dec.aluop  = AluBranch;
          dec.imm    = imm_b;
          dec.branch = 1'b1;
        end
      end
      OpcJal: begin
        dec.asel  = 2'd1;
        dec.bsel  = 1'b1;
        dec.imm   = imm_j;
        dec.jump  = 1'b1;
        dec.rd_we = 1'b1;
      end
      OpcJalr: begin
        dec.bsel  = 1'b1;
        dec.imm   = imm_i;
        dec.jump  = 1'b1;
        dec.rd_we = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  logic out_vld_q, out_vld_d;
  dec_t out_dat_q, out_dat_d;
  logic skid_vld_q, skid_vld_d;
  dec_t skid_dat_q, skid_dat_d;
  logic in_rdy, in_xfer, out_free;

  // With the skid entry, ready comes straight from a flop so out_ready_i never reaches in_ready_o.
  assign in_rdy   = SkidEn ? !skid_vld_q : (!out_vld_q || out_ready_i);
  assign in_xfer  = in_valid_i && in_rdy;
  assign out_free = !out_vld_q || out_ready_i;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        out_dat_d  = skid_dat_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        out_dat_d = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_dat_d = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign in_ready_o  = in_rdy;
  assign out_valid_o = out_vld_q;
  assign pc_o        = out_dat_q.pc;
  assign rs1_o       = out_dat_q.rs1;
  assign rs2_o       = out_dat_q.rs2;
  assign rd_o        = out_dat_q.rd;
  assign rd_we_o     = out_dat_q.rd_we;
  assign imm_o       = out_dat_q.imm;
  assign funct3_o    = out_dat_q.funct3;
  assign funct7_o    = out_dat_q.funct7;
  assign itype_o     = out_dat_q.itype;
  assign aluop_o     = out_dat_q.aluop;
  assign asel_o      = out_dat_q.asel;
  assign bsel_o      = out_dat_q.bsel;
  assign mem_read_o  = out_dat_q.mem_read;
  assign mem_write_o = out_dat_q.mem_write;
  assign branch_o    = out_dat_q.branch;
  assign jump_o      = out_dat_q.jump;
  assign illegal_o   = out_dat_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan steps, then random traffic against a queue-based model.
module tb_decode_stage;
  import core_pkg::*;

  typedef logic [100:0] bund_t;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [31:0] instr_i, pc_i, pc_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        rd_we_o, itype_o, bsel_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [1:0]  asel_o;
  aluop_e      aluop_o;

  int    total = 0;
  int    bad = 0;
  bund_t exp_q[$];
  bund_t obs;

  always #5 clk_i = ~clk_i;

  decode_stage #(.SkidEn(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .imm_o(imm_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .itype_o(itype_o),
    .aluop_o(aluop_o), .asel_o(asel_o), .bsel_o(bsel_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o)
  );

  assign obs = {pc_o, rs1_o, rs2_o, rd_o, rd_we_o, imm_o, funct3_o, funct7_o, itype_o,
                aluop_o, asel_o, bsel_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o};

  // Reference decode: immediates built arithmetically from the field weights.
  function automatic bund_t ref_model(input logic [31:0] ins, input logic [31:0] pc);
    int          f3;
    logic [31:0] imm, i_imm, s_imm, b_imm, j_imm, u_imm;
    logic [1:0]  op, asel;
    logic        bsel, we, mr, mw, br, jp, il, it;
    f3    = int'(ins[14:12]);
    i_imm = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
    s_imm = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
    b_imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    j_imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    u_imm = ins & 32'hFFFF_F000;
    imm = 0; op = 2'd0; asel = 2'd0;
    {bsel, we, mr, mw, br, jp, il, it} = '0;
    case (ins[6:0])
      7'h33: begin op = 2'd3; we = 1; end
      7'h13: begin op = 2'd3; it = 1; bsel = 1; imm = i_imm; we = 1; end
      7'h37: begin asel = 2'd2; bsel = 1; imm = u_imm; we = 1; end
      7'h17: begin asel = 2'd1; bsel = 1; imm = u_imm; we = 1; end
      7'h03: if (f3 == 3 || f3 >= 6) il = 1; else begin bsel = 1; imm = i_imm; mr = 1; we = 1; end
      7'h23: if (f3 >= 3) il = 1; else begin bsel = 1; imm = s_imm; mw = 1; end
      7'h63: if (f3 == 2 || f3 == 3) il = 1; else begin op = 2'd2; imm = b_imm; br = 1; end
      7'h6F: begin asel = 2'd1; bsel = 1; imm = j_imm; jp = 1; we = 1; end
      7'h67: begin bsel = 1; imm = i_imm; jp = 1; we = 1; end
      default: il = 1;
    endcase
    return {pc, ins[19:15], ins[24:20], ins[11:7], we, imm, ins[14:12], ins[31:25], it,
            op, asel, bsel, mr, mw, br, jp, il};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k   = $urandom_range(0, 9);
    if (k < 9) ins[6:0] = opcs[k];
    return ins;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle, update the model at the handshake point, check after the edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic rs, input string tag);
    logic in_x, out_x;
    in_valid_i = v; instr_i = ins; pc_i = pc; out_ready_i = ordy; flush_i = fl; rst_i = rs;
    #1;
    in_x  = v && in_ready_o;
    out_x = out_valid_o && ordy;
    if (fl || rs) begin
      exp_q.delete();
    end else begin
      if (out_x && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_x) exp_q.push_back(ref_model(ins, pc));
    end
    @(negedge clk_i);
    chk({tag, ".out_valid"}, out_valid_o, exp_q.size() > 0);
    chk({tag, ".in_ready"}, in_ready_o, exp_q.size() < 2);
    if (exp_q.size() > 0) chk({tag, ".bundle"}, obs, exp_q[0]);
  endtask

  localparam logic [31:0] InsA = 32'h0010_0093;
  localparam logic [31:0] InsB = 32'h0020_0113;
  localparam logic [31:0] InsC = 32'h0030_0193;
  localparam logic [31:0] InsD = 32'h0040_0213;

  initial begin
    rst_i = 1; flush_i = 0; in_valid_i = 0; out_ready_i = 0; instr_i = 0; pc_i = 0;

    cyc(0, 0, 0, 1, 0, 1, "rst0");
    cyc(0, 0, 0, 1, 0, 1, "rst1");
    chk("rst.data", obs, '0);
    chk("rst.aluop", aluop_o, AluAdd);
    chk("rst.in_ready", in_ready_o, 1'b1);

    cyc(1, 32'h0020_81B3, 32'h100, 1, 0, 0, "add");
    chk("add.fields", {aluop_o, funct3_o, funct7_o, itype_o, rs1_o, rs2_o, rd_o, rd_we_o, asel_o, bsel_o},
        {AluFunct, 3'd0, 7'h00, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 2'd0, 1'b0});
    cyc(1, 32'h4033_5293, 32'h104, 1, 0, 0, "srai");
    chk("srai.fields", {aluop_o, itype_o, funct3_o, funct7_o, imm_o, bsel_o, rd_o},
        {AluFunct, 1'b1, 3'd5, 7'h20, 32'h0000_0403, 1'b1, 5'd5});
    cyc(1, 32'hFE20_8EE3, 32'h108, 1, 0, 0, "beq");
    chk("beq.fields", {aluop_o, branch_o, imm_o, rd_we_o}, {AluBranch, 1'b1, 32'hFFFF_FFFC, 1'b0});
    cyc(1, 32'h0000_0000, 32'h10C, 1, 0, 0, "zero");
    chk("zero.fields", {illegal_o, rd_we_o, mem_read_o, mem_write_o}, 4'b1000);
    cyc(0, 0, 0, 1, 0, 0, "drain0");

    cyc(1, InsA, 32'h200, 0, 0, 0, "bpA");
    cyc(1, InsB, 32'h204, 0, 0, 0, "bpB");
    cyc(1, InsC, 32'h208, 0, 0, 0, "bpC");
    chk("bp.held_ready", in_ready_o, 1'b0);
    chk("bp.held_pc", pc_o, 32'h200);
    cyc(1, InsC, 32'h208, 1, 0, 0, "bpR1");
    chk("bp.second_pc", pc_o, 32'h204);
    cyc(1, InsC, 32'h208, 1, 0, 0, "bpR2");
    chk("bp.third_pc", pc_o, 32'h208);
    cyc(0, 0, 0, 1, 0, 0, "bpR3");

    cyc(1, InsA, 32'h300, 0, 0, 0, "flA");
    cyc(1, InsB, 32'h304, 0, 0, 0, "flB");
    cyc(1, InsC, 32'h308, 0, 1, 0, "flush_full");
    chk("flush_full.state", {out_valid_o, in_ready_o}, 2'b01);
    cyc(1, InsA, 32'h310, 0, 0, 0, "fl1A");
    cyc(1, InsB, 32'h314, 0, 1, 0, "flush_hs");
    chk("flush_hs.state", {out_valid_o, in_ready_o}, 2'b01);
    cyc(0, 0, 0, 1, 0, 0, "fl_idle");
    cyc(1, InsD, 32'h318, 1, 0, 0, "fl_after");
    chk("fl_after.pc", pc_o, 32'h318);
    cyc(0, 0, 0, 1, 0, 0, "drain1");

    cyc(1, InsA, 32'h400, 0, 0, 0, "rmA");
    cyc(1, InsB, 32'h404, 0, 0, 0, "rmB");
    cyc(1, InsC, 32'h408, 0, 0, 1, "rm_rst");
    chk("rm.state", {out_valid_o, in_ready_o}, 2'b01);
    chk("rm.data", obs, '0);
    cyc(1, 32'h0050_0093, 32'h40C, 1, 0, 0, "addi");
    chk("addi.fields", {out_valid_o, imm_o, itype_o}, {1'b1, 32'd5, 1'b1});
    cyc(0, 0, 0, 1, 0, 0, "drain2");

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0, "rand");
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, "final_drain");
    chk("final.empty", out_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
